// File: rtl/pc_fetch_sequencer.sv
// PC owner/fetch sequencer: FETCH waits on IMEM_READY, ISSUE holds INSTR while STALL is high.
// Latency: at least 2 cycles per instruction; each IMEM_READY-low or STALL-high cycle adds one.
module pc_fetch_sequencer #(
    parameter int          AW  = 8,
    parameter int          IW  = 32,
    parameter int unsigned INC = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IMEM_READY,
    input  logic [IW-1:0] IMEM_RDATA,
    input  logic          STALL,
    input  logic          BRANCH_TAKEN,
    input  logic [AW-1:0] BRANCH_OFFSET,
    input  logic          JUMP,
    input  logic [AW-1:0] JUMP_TARGET,
    output logic [AW-1:0] PC,
    output logic          IMEM_READ,
    output logic [IW-1:0] INSTR,
    output logic          INSTR_VALID,
    output logic [7:0]    RETIRED
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [AW-1:0] INC_W = AW'(INC);

    state_t        state;
    logic [AW-1:0] pc_seq;
    logic [AW-1:0] next_pc;

    assign pc_seq = PC + INC_W;

    // An AW-bit offset added modulo 2^AW is identical to adding its sign extension.
    always_comb begin
        next_pc = pc_seq;
        if (JUMP) begin
            next_pc = JUMP_TARGET;
        end else if (BRANCH_TAKEN) begin
            next_pc = pc_seq + BRANCH_OFFSET;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            PC          <= '0;
            INSTR       <= '0;
            RETIRED     <= '0;
            IMEM_READ   <= 1'b0;
            INSTR_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    IMEM_READ <= 1'b1;
                end
                FETCH: begin
                    if (IMEM_READY) begin
                        INSTR       <= IMEM_RDATA;
                        state       <= ISSUE;
                        IMEM_READ   <= 1'b0;
                        INSTR_VALID <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Control-flow inputs are only sampled on the accepting edge.
                    if (!STALL) begin
                        RETIRED     <= RETIRED + 8'd1;
                        PC          <= next_pc;
                        state       <= FETCH;
                        INSTR_VALID <= 1'b0;
                        IMEM_READ   <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    IMEM_READ   <= 1'b0;
                    INSTR_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
